m2_block_scheduler: RTL and testbench
=====================================

# m2_block_scheduler

Top-level sequencer for milestone 2 (IDCT decode). It runs the four per-block engines through the whole frame: FS fetches S' into DPRAM0, CT computes T, CS computes S, and WS writes S back to SRAM. It overlaps memory-bound and multiplier-bound stages, owns the single SRAM port and muxes it between FS (reads) and WS (writes). It tracks the 8x8 block index across the Y, U and V segments and flags completion to the top-level FSM.

## Interface
- NUM_BLOCKS, 2400: total 8x8 blocks per frame (1200 Y + 600 U + 600 V); minimum 1.
- Y_BLOCKS, 1200: blocks in the Y segment.
- U_BLOCKS, 600: blocks in the U segment; the V segment starts at index Y_BLOCKS+U_BLOCKS.
- CLOCK_50_I  in  1  50 MHz clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- M2_start  in  1  1-cycle pulse that begins a frame; ignored unless in S_IDLE or S_DONE.
- M2_done  out  1  level; high in S_DONE until the next accepted M2_start or Reset.
- FS_start, CT_start, CS_start, WS_start  out  1 each  1-cycle start pulses to the engines.
- FS_done, CT_done, CS_done, WS_done  in  1 each  1-cycle completion pulses from the engines.
- block_index  out  12  index of the block CT/CS are working on (FS works on block_index+1, WS on block_index-1).
- segment  out  2  0 = Y, 1 = U, 2 = V, decoded from block_index.
- FS_SRAM_address  in  18  FS read address.
- WS_SRAM_address  in  18  WS write address.
- WS_SRAM_write_data  in  16  WS write data.
- WS_SRAM_we_n  in  1  WS active-low write enable.
- SRAM_address  out  18  muxed SRAM address.
- SRAM_write_data  out  16  muxed SRAM write data.
- SRAM_we_n  out  1  muxed SRAM write enable, active low.

## Operation
- States: S_IDLE, S_LEAD_FS, S_MEGA_A, S_MEGA_B, S_LEAD_WS, S_DONE.
- S_IDLE/S_DONE --M2_start--> S_LEAD_FS. On that transition: block_index ← 0, M2_done ← 0.
- S_LEAD_FS: FS on block 0. On FS_done → S_MEGA_A.
- S_MEGA_A: CT(k) runs, plus WS(k-1) when k > 0. Leave when every started engine has reported done. Then → S_MEGA_B.
- S_MEGA_B: CS(k) runs, plus FS(k+1) when k < NUM_BLOCKS-1. When all started engines are done:
  - if k < NUM_BLOCKS-1: block_index ← k+1, → S_MEGA_A;
  - else → S_LEAD_WS.
- S_LEAD_WS: WS on the last block. On WS_done → S_DONE, M2_done ← 1.
- Done tracking:
  - One sticky flag per engine, cleared on state entry.
  - A flag is set by its done pulse.
  - An engine not started in the current state counts as already done.
  - A done pulse from an engine not started in the current state is ignored.
- Exit condition is evaluated combinationally: (sticky flag OR done pulse this cycle), so a done arriving on the final cycle counts immediately.
- SRAM ownership:
  - FS owns the port in S_LEAD_FS and S_MEGA_B.
  - WS owns the port in S_MEGA_A (k > 0) and S_LEAD_WS.
  - By construction FS and WS never overlap.
- SRAM mux, combinational:
  - FS owner: SRAM_address = FS_SRAM_address, SRAM_we_n = 1.
  - WS owner: SRAM_address, SRAM_write_data and SRAM_we_n come from the WS inputs.
  - No owner: address 0, data 0, we_n 1.
- segment: 0 if block_index < Y_BLOCKS; 1 if < Y_BLOCKS+U_BLOCKS; else 2.

## Timing
- Reset values (cycle after Reset high), regardless of current state:
  - state S_IDLE; all *_start 0; M2_done 0; block_index 0; segment 0; SRAM_we_n 1; SRAM_address 0; SRAM_write_data 0.
  - All sticky flags cleared.
- Start pulses are registered. They are high for exactly the first cycle of the state that starts the engine, i.e. the cycle after the transition decision.
- Minimum dwell is 2 cycles per state. A done pulse is never expected in the same cycle as its start.
- M2_start → FS_start: 1 cycle (S_LEAD_FS entered on the next edge; FS_start high in that first cycle).
- Last required done → next state's start pulses: 1 cycle.
- WS_done in S_LEAD_WS → M2_done high on the next edge.
- Simultaneous done pulses from both engines in one cycle: state exits on the following edge.

## Test plan
- Reset check: apply Reset mid S_MEGA_B with NUM_BLOCKS=4 → next cycle state S_IDLE, all outputs at reset values, no start pulse, SRAM_we_n=1.
- Full sequence with NUM_BLOCKS=3, engines as fixed 5-cycle responders:
  - required start order: FS0; CT0; CS0+FS1; CT1+WS0; CS1+FS2; CT2+WS1; CS2; WS2; then M2_done=1.
  - block_index steps 0,1,2.
- Done ordering in S_MEGA_A (k=1):
  - WS_done 3 cycles before CT_done → exit 1 cycle after CT_done.
  - Same in reverse order.
  - Simultaneous pulses → exit 1 cycle after.
  - A stray FS_done in S_MEGA_A is ignored.
- SRAM mux: FS_SRAM_address=18'h12C00 and WS_SRAM_address=18'h00140 with WS_SRAM_we_n=0:
  - in S_MEGA_B, SRAM_address=18'h12C00 and SRAM_we_n=1;
  - in S_MEGA_A (k>0), SRAM_address=18'h00140 and SRAM_we_n=0;
  - in S_IDLE, SRAM_address=0 and SRAM_we_n=1.
- Degenerate case NUM_BLOCKS=1: FS0, CT0 (no WS_start), CS0 (no FS_start), WS0, then M2_done. A second M2_start while busy is ignored; M2_start from S_DONE restarts with M2_done cleared.
- Segment decode (defaults): block_index 1199 → segment 0; 1200 → 1; 1799 → 1; 1800 → 2. Index is forced via a fast responder run.

Source files
------------

// File: rtl/m2_block_scheduler.sv
// m2_block_scheduler
// Frame-level sequencer for the milestone 2 IDCT decode. Walks the 8x8 block
// index through the Y, U and V segments and overlaps the four per-block
// engines: FS (fetch S'), CT (compute T), CS (compute S) and WS (write S).
// Owns the single SRAM port and hands it to FS (reads) or WS (writes).
//
// Ports
//   CLOCK_50_I          clock, rising edge
//   Reset               synchronous, active-high reset
//   M2_start            1-cycle frame start pulse (accepted in S_IDLE/S_DONE)
//   M2_done             level, high in S_DONE
//   *_start / *_done    start pulses to / done pulses from FS, CT, CS, WS
//   block_index         block CT/CS work on (FS: +1, WS: -1)
//   segment             0 = Y, 1 = U, 2 = V
//   FS_SRAM_*, WS_SRAM_* engine-side SRAM requests
//   SRAM_*              muxed SRAM port
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | waiting for M2_start
// S_LEAD_FS | FS fetches block 0 (pipeline fill)
// S_MEGA_A  | CT(k), plus WS(k-1) when k > 0
// S_MEGA_B  | CS(k), plus FS(k+1) when k is not the last block
// S_LEAD_WS | WS writes the last block (pipeline drain)
// S_DONE    | frame complete, M2_done high

module m2_block_scheduler #(
    parameter int NUM_BLOCKS = 2400,
    parameter int Y_BLOCKS   = 1200,
    parameter int U_BLOCKS   = 600
) (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    input  logic        M2_start,
    output logic        M2_done,
    output logic        FS_start,
    output logic        CT_start,
    output logic        CS_start,
    output logic        WS_start,
    input  logic        FS_done,
    input  logic        CT_done,
    input  logic        CS_done,
    input  logic        WS_done,
    output logic [11:0] block_index,
    output logic [1:0]  segment,
    input  logic [17:0] FS_SRAM_address,
    input  logic [17:0] WS_SRAM_address,
    input  logic [15:0] WS_SRAM_write_data,
    input  logic        WS_SRAM_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    localparam logic [11:0] LAST_IDX = 12'(NUM_BLOCKS - 1);
    localparam logic [11:0] Y_END    = 12'(Y_BLOCKS);
    localparam logic [11:0] UV_END   = 12'(Y_BLOCKS + U_BLOCKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_FS,
        S_MEGA_A,
        S_MEGA_B,
        S_LEAD_WS,
        S_DONE
    } state_t;

    state_t state;

    logic fs_flag, ct_flag, cs_flag, ws_flag;
    logic fs_run, ct_run, cs_run, ws_run;
    logic not_first, not_last;
    logic all_done, advance;

    assign not_first = (block_index != 12'd0);
    assign not_last  = (block_index < LAST_IDX);

    // Engines started in the current state; anything else counts as done
    // and its done pulse is ignored.
    always_comb begin
        fs_run = 1'b0;
        ct_run = 1'b0;
        cs_run = 1'b0;
        ws_run = 1'b0;
        case (state)
            S_LEAD_FS: fs_run = 1'b1;
            S_MEGA_A: begin
                ct_run = 1'b1;
                ws_run = not_first;
            end
            S_MEGA_B: begin
                cs_run = 1'b1;
                fs_run = not_last;
            end
            S_LEAD_WS: ws_run = 1'b1;
            default: ;
        endcase
    end

    // A done pulse on the final cycle counts without waiting for its flag.
    assign all_done = (!fs_run || fs_flag || FS_done) &&
                      (!ct_run || ct_flag || CT_done) &&
                      (!cs_run || cs_flag || CS_done) &&
                      (!ws_run || ws_flag || WS_done);

    always_comb begin
        case (state)
            S_IDLE, S_DONE: advance = M2_start;
            S_LEAD_FS, S_MEGA_A, S_MEGA_B, S_LEAD_WS: advance = all_done;
            default: advance = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state       <= S_IDLE;
            M2_done     <= 1'b0;
            FS_start    <= 1'b0;
            CT_start    <= 1'b0;
            CS_start    <= 1'b0;
            WS_start    <= 1'b0;
            block_index <= 12'd0;
            fs_flag     <= 1'b0;
            ct_flag     <= 1'b0;
            cs_flag     <= 1'b0;
            ws_flag     <= 1'b0;
        end else begin
            FS_start <= 1'b0;
            CT_start <= 1'b0;
            CS_start <= 1'b0;
            WS_start <= 1'b0;

            if (advance) begin
                fs_flag <= 1'b0;
                ct_flag <= 1'b0;
                cs_flag <= 1'b0;
                ws_flag <= 1'b0;
            end else begin
                if (fs_run && FS_done) fs_flag <= 1'b1;
                if (ct_run && CT_done) ct_flag <= 1'b1;
                if (cs_run && CS_done) cs_flag <= 1'b1;
                if (ws_run && WS_done) ws_flag <= 1'b1;
            end

            if (advance) begin
                case (state)
                    S_IDLE, S_DONE: begin
                        state       <= S_LEAD_FS;
                        block_index <= 12'd0;
                        M2_done     <= 1'b0;
                        FS_start    <= 1'b1;
                    end
                    S_LEAD_FS: begin
                        // block 0: nothing to write back yet
                        state    <= S_MEGA_A;
                        CT_start <= 1'b1;
                    end
                    S_MEGA_A: begin
                        state    <= S_MEGA_B;
                        CS_start <= 1'b1;
                        FS_start <= not_last;
                    end
                    S_MEGA_B: begin
                        if (not_last) begin
                            state       <= S_MEGA_A;
                            block_index <= block_index + 12'd1;
                            CT_start    <= 1'b1;
                            WS_start    <= 1'b1;
                        end else begin
                            state    <= S_LEAD_WS;
                            WS_start <= 1'b1;
                        end
                    end
                    S_LEAD_WS: begin
                        state   <= S_DONE;
                        M2_done <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // FS and WS never run in the same state, so ownership is exclusive.
    always_comb begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        if (ws_run) begin
            SRAM_address    = WS_SRAM_address;
            SRAM_write_data = WS_SRAM_write_data;
            SRAM_we_n       = WS_SRAM_we_n;
        end else if (state == S_LEAD_FS || state == S_MEGA_B) begin
            SRAM_address = FS_SRAM_address;
        end
    end

    always_comb begin
        if (block_index < Y_END)       segment = 2'd0;
        else if (block_index < UV_END) segment = 2'd1;
        else                           segment = 2'd2;
    end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Directed bench for m2_block_scheduler. Four instances share clock/reset:
//   0: NUM_BLOCKS=4    hand-driven done pulses, SRAM mux, mid-run reset
//   1: NUM_BLOCKS=3    fixed 5-cycle responders, full start order
//   2: NUM_BLOCKS=1    degenerate frame, busy/restart M2_start handling
//   3: NUM_BLOCKS=2400 1-cycle responders, segment decode
// Start vectors are {WS, CS, CT, FS}.

module tb_m2_block_scheduler;

    function automatic int nb_of(int g);
        case (g)
            0: return 4;
            1: return 3;
            2: return 1;
            default: return 2400;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  m2_start;
    logic [3:0]  auto_done [4];
    logic [3:0]  man_done [4];
    logic [3:0]  auto_en;
    int          auto_lat [4];
    int          cnt [4][4];

    logic [17:0] fs_addr, ws_addr;
    logic [15:0] ws_data;
    logic        ws_we_n;

    wire  [3:0]  st_w [4];
    wire  [3:0]  m2d;
    wire  [11:0] bi_w [4];
    wire  [1:0]  seg_w [4];
    wire  [17:0] addr_w [4];
    wire  [15:0] wd_w [4];
    wire  [3:0]  we_w;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wire [3:0] dn = auto_done[g] | man_done[g];
        wire fs_s, ct_s, cs_s, ws_s;
        assign st_w[g] = {ws_s, cs_s, ct_s, fs_s};
        m2_block_scheduler #(.NUM_BLOCKS(nb_of(g))) u_dut (
            .CLOCK_50_I        (clk),
            .Reset             (rst),
            .M2_start          (m2_start[g]),
            .M2_done           (m2d[g]),
            .FS_start          (fs_s),
            .CT_start          (ct_s),
            .CS_start          (cs_s),
            .WS_start          (ws_s),
            .FS_done           (dn[0]),
            .CT_done           (dn[1]),
            .CS_done           (dn[2]),
            .WS_done           (dn[3]),
            .block_index       (bi_w[g]),
            .segment           (seg_w[g]),
            .FS_SRAM_address   (fs_addr),
            .WS_SRAM_address   (ws_addr),
            .WS_SRAM_write_data(ws_data),
            .WS_SRAM_we_n      (ws_we_n),
            .SRAM_address      (addr_w[g]),
            .SRAM_write_data   (wd_w[g]),
            .SRAM_we_n         (we_w[g])
        );
    end

    // Fixed-latency engine models: done pulses auto_lat cycles after start.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            for (int e = 0; e < 4; e++) begin
                auto_done[d][e] = 1'b0;
                if (auto_en[d]) begin
                    if (st_w[d][e]) cnt[d][e] = auto_lat[d];
                    else if (cnt[d][e] > 0) begin
                        cnt[d][e] = cnt[d][e] - 1;
                        if (cnt[d][e] == 0) auto_done[d][e] = 1'b1;
                    end
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int d);
        m2_start[d] = 1'b1;
        @(negedge clk);
        m2_start[d] = 1'b0;
    endtask

    task automatic pdone(input int d, input logic [3:0] mask);
        man_done[d] = mask;
        @(negedge clk);
        man_done[d] = 4'b0000;
    endtask

    logic [3:0]  rec_v [16];
    logic [11:0] rec_b [16];
    int          rec_c [16];
    int          rec_n;
    int          done_cyc;

    // Logs every cycle with a start pulse until M2_done; optionally pokes
    // M2_start at cycle 'poke' to confirm it is ignored while busy.
    task automatic record(input int d, input int poke);
        rec_n = 0;
        done_cyc = -1;
        for (int c = 0; c < 400; c++) begin
            if (m2d[d]) begin
                done_cyc = c;
                break;
            end
            if (c == poke) m2_start[d] = 1'b1;
            else if (c == poke + 1) m2_start[d] = 1'b0;
            if (st_w[d] != 4'b0000) begin
                if (rec_n < 16) begin
                    rec_v[rec_n] = st_w[d];
                    rec_b[rec_n] = bi_w[d];
                    rec_c[rec_n] = c;
                end
                rec_n++;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_bi(input int d, input logic [11:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (bi_w[d] == v) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [3:0]  exp3_v [8] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010,
                                4'b0101, 4'b1010, 4'b0100, 4'b1000};
    logic [11:0] exp3_b [8] = '{12'd0, 12'd0, 12'd0, 12'd1,
                                12'd1, 12'd2, 12'd2, 12'd2};
    logic [3:0]  exp1_v [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        bit ok;
        rst      = 1'b1;
        m2_start = 4'b0000;
        auto_en  = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            man_done[d] = 4'b0000;
            auto_lat[d] = 5;
        end
        fs_addr = 18'h12C00;
        ws_addr = 18'h00140;
        ws_data = 16'hBEEF;
        ws_we_n = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        // reset state
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_start_%0d", d), st_w[d], 4'b0000);
            chk($sformatf("rst_done_%0d", d), m2d[d], 1'b0);
            chk($sformatf("rst_bi_%0d", d), bi_w[d], 12'd0);
            chk($sformatf("rst_seg_%0d", d), seg_w[d], 2'd0);
        end
        chk("idle_addr", addr_w[0], 18'd0);
        chk("idle_data", wd_w[0], 16'd0);
        chk("idle_we_n", we_w[0], 1'b1);

        // full sequence, 3 blocks, 5-cycle engines
        auto_en[1] = 1'b1;
        pulse_start(1);
        record(1, -1);
        chk("full_count", rec_n, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_start_%0d", i), rec_v[i], exp3_v[i]);
            chk($sformatf("full_bi_%0d", i), rec_b[i], exp3_b[i]);
            chk($sformatf("full_cyc_%0d", i), rec_c[i], 6 * i);
        end
        chk("full_done_cyc", done_cyc, 48);
        step(3);
        chk("full_done_hold", m2d[1], 1'b1);

        // degenerate frame, busy M2_start ignored
        auto_en[2] = 1'b1;
        pulse_start(2);
        record(2, 3);
        chk("one_count", rec_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("one_start_%0d", i), rec_v[i], exp1_v[i]);
            chk($sformatf("one_bi_%0d", i), rec_b[i], 12'd0);
            chk($sformatf("one_cyc_%0d", i), rec_c[i], 6 * i);
        end
        chk("one_done_cyc", done_cyc, 24);
        pulse_start(2);
        chk("restart_done_clr", m2d[2], 1'b0);
        chk("restart_fs", st_w[2], 4'b0001);
        chk("restart_bi", bi_w[2], 12'd0);

        // segment decode with fast engines
        auto_lat[3] = 1;
        auto_en[3]  = 1'b1;
        pulse_start(3);
        wait_bi(3, 12'd1199, 6000, ok);
        chk("seg_reach_1199", ok, 1'b1);
        chk("seg_1199", seg_w[3], 2'd0);
        wait_bi(3, 12'd1200, 100, ok);
        chk("seg_reach_1200", ok, 1'b1);
        chk("seg_1200", seg_w[3], 2'd1);
        wait_bi(3, 12'd1799, 2500, ok);
        chk("seg_reach_1799", ok, 1'b1);
        chk("seg_1799", seg_w[3], 2'd1);
        wait_bi(3, 12'd1800, 100, ok);
        chk("seg_reach_1800", ok, 1'b1);
        chk("seg_1800", seg_w[3], 2'd2);

        // hand-driven 4-block frame
        pulse_start(0);
        chk("m_fs0", st_w[0], 4'b0001);
        chk("m_fs0_addr", addr_w[0], 18'h12C00);
        step(1);
        pdone(0, 4'b0001);
        chk("m_ct0", st_w[0], 4'b0010);
        chk("m_ct0_addr", addr_w[0], 18'd0);
        chk("m_ct0_we_n", we_w[0], 1'b1);
        step(1);
        pdone(0, 4'b0010);
        chk("m_b0", st_w[0], 4'b0101);
        chk("mux_b_addr", addr_w[0], 18'h12C00);
        chk("mux_b_we_n", we_w[0], 1'b1);
        step(1);
        pdone(0, 4'b0100);
        chk("m_b0_hold_addr", addr_w[0], 18'h12C00);
        chk("m_b0_hold_bi", bi_w[0], 12'd0);
        step(1);
        pdone(0, 4'b0001);
        chk("m_a1", st_w[0], 4'b1010);
        chk("m_a1_bi", bi_w[0], 12'd1);
        chk("mux_a_addr", addr_w[0], 18'h00140);
        chk("mux_a_we_n", we_w[0], 1'b0);
        chk("mux_a_data", wd_w[0], 16'hBEEF);

        // k=1: WS_done, stray FS_done, CT_done three cycles after WS
        step(1);
        pdone(0, 4'b1000);
        pdone(0, 4'b0001);
        step(1);
        chk("ord_ws_first_hold", addr_w[0], 18'h00140);
        pdone(0, 4'b0010);
        chk("ord_ws_first_exit", st_w[0], 4'b0101);
        chk("ord_ws_first_bi", bi_w[0], 12'd1);

        // MEGA_B k=1: CS and FS together
        step(1);
        pdone(0, 4'b0101);
        chk("m_a2", st_w[0], 4'b1010);
        chk("m_a2_bi", bi_w[0], 12'd2);

        // k=2: CT_done first, WS_done three cycles later
        step(1);
        pdone(0, 4'b0010);
        step(2);
        chk("ord_ct_first_hold", we_w[0], 1'b0);
        pdone(0, 4'b1000);
        chk("ord_ct_first_exit", st_w[0], 4'b0101);
        chk("ord_ct_first_bi", bi_w[0], 12'd2);
        step(1);
        pdone(0, 4'b0101);
        chk("m_a3", st_w[0], 4'b1010);
        chk("m_a3_bi", bi_w[0], 12'd3);

        // k=3: WS and CT together, last block so no FS in MEGA_B
        step(1);
        pdone(0, 4'b1010);
        chk("m_b3_cs_only", st_w[0], 4'b0100);
        chk("m_b3_bi", bi_w[0], 12'd3);
        chk("m_b3_addr", addr_w[0], 18'h12C00);

        // reset in the middle of MEGA_B
        step(1);
        rst = 1'b1;
        step(1);
        chk("mrst_start", st_w[0], 4'b0000);
        chk("mrst_done", m2d[0], 1'b0);
        chk("mrst_bi", bi_w[0], 12'd0);
        chk("mrst_seg", seg_w[0], 2'd0);
        chk("mrst_addr", addr_w[0], 18'd0);
        chk("mrst_data", wd_w[0], 16'd0);
        chk("mrst_we_n", we_w[0], 1'b1);
        chk("mrst_full_done", m2d[1], 1'b0);
        chk("mrst_seg_bi", bi_w[3], 12'd0);
        rst = 1'b0;
        step(1);
        chk("mrst_idle_start", st_w[0], 4'b0000);
        pulse_start(0);
        chk("mrst_restart_fs", st_w[0], 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
